game_tick_controller: RTL and testbench

- Parametrised successor to the fixed half-period screen-clock divider in the snake top level.
- Generates a single-cycle game tick enable from `clock`, plus a legacy square wave for blocks still sampling a screen clock.
- Game speed is level-dependent and rises as apples are eaten.
- Owns the game run state (idle/run/pause/over); the snake, collision and scoreboard blocks consume `tick`, `level` and `state`.

---
 rtl/game_pkg.sv | 43 ++++
 rtl/tick_divider.sv | 73 +++++++
 rtl/game_tick_controller.sv | 135 +++++++++++++
 tb/tb_game_tick_controller.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// rtl/game_pkg.sv - shared state encodings, default periods and the period rule for the game tick controller
//
// Purpose: types and helpers shared by game_tick_controller and tick_divider.
//   game_state_e  : 2-bit game run state (IDLE/RUN/PAUSE/OVER)
//   DEF_*         : default timing/level constants (50 MHz board, 4 Hz start speed)
//   calc_period() : level-dependent tick period with a floor, no unsigned underflow

package game_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_OVER  = 2'd3
  } game_state_e;

  localparam int DEF_BASE_PERIOD      = 12500000;
  localparam int DEF_STEP_PERIOD      = 1250000;
  localparam int DEF_MIN_PERIOD       = 2500000;
  localparam int DEF_CNT_W            = 24;
  localparam int DEF_LEVEL_W          = 4;
  localparam int DEF_MAX_LEVEL        = 8;
  localparam int DEF_APPLES_PER_LEVEL = 5;

  // max(base - level*step, min) evaluated without ever subtracting past zero.
  // The product is formed wide enough that it cannot wrap for any legal
  // level/step combination, so the comparison against (base - min) is exact.
  function automatic logic [63:0] calc_period(input logic [31:0] level,
                                               input logic [31:0] base_p,
                                               input logic [31:0] step_p,
                                               input logic [31:0] min_p);
    logic [63:0] prod;
    prod = 64'(level) * 64'(step_p);
    if (base_p <= min_p) begin
      calc_period = 64'(min_p);
    end else if (prod >= 64'(base_p - min_p)) begin
      calc_period = 64'(min_p);
    end else begin
      calc_period = 64'(base_p) - prod;
    end
  endfunction

endpackage

// File: rtl/tick_divider.sv
// rtl/tick_divider.sv - reloadable period counter producing a one-cycle tick and a toggling legacy clock
//
// Purpose: counts enabled cycles and emits a tick when the count reaches the
// active period; the next period is sampled only at that wrap, so a period in
// progress is never shortened.
// Ports:
//   clock          in   system clock
//   reset          in   asynchronous, active-high
//   enable_i       in   count this cycle (game running and staying in RUN)
//   clear_i        in   restart: count <= 0, period <= period_i, tick <= 0
//   period_i       in   period loaded on clear or at the wrap
//   tick_o         out  registered one-cycle tick
//   tick_toggle_o  out  registered, inverts on every tick

module tick_divider #(
  parameter int CNT_W        = 24,
  parameter int RESET_PERIOD = 12500000
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable_i,
  input  logic             clear_i,
  input  logic [CNT_W-1:0] period_i,
  output logic             tick_o,
  output logic             tick_toggle_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic             tick_q, tick_d;
  logic             toggle_q, toggle_d;
  logic             wrap;

  assign wrap = (cnt_q == period_q - CNT_W'(1));

  always_comb begin
    cnt_d    = cnt_q;
    period_d = period_q;
    tick_d   = 1'b0;
    toggle_d = toggle_q;
    if (clear_i) begin
      cnt_d    = '0;
      period_d = period_i;
    end else if (enable_i) begin
      if (wrap) begin
        cnt_d    = '0;
        tick_d   = 1'b1;
        toggle_d = ~toggle_q;
        period_d = period_i;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_q    <= '0;
      period_q <= CNT_W'(RESET_PERIOD);
      tick_q   <= 1'b0;
      toggle_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      period_q <= period_d;
      tick_q   <= tick_d;
      toggle_q <= toggle_d;
    end
  end

  assign tick_o        = tick_q;
  assign tick_toggle_o = toggle_q;

endmodule

// File: rtl/game_tick_controller.sv
// rtl/game_tick_controller.sv - game run-state FSM, apple/level tracking and level-dependent tick generation
//
// Purpose: owns the game run state and speed level and drives the game-step
// tick consumed by the snake, collision and scoreboard blocks.
// Ports:
//   clock           in   system clock
//   reset           in   asynchronous, active-high
//   start_i         in   pulse: begin/restart game (IDLE or OVER only)
//   pause_toggle_i  in   pulse: RUN <-> PAUSE
//   collision_i     in   pulse: game over (beats pause and apple)
//   apple_eaten_i   in   pulse: apple consumed (RUN only)
//   tick_o          out  one-cycle game-step enable
//   tick_toggle_o   out  legacy screen clock, inverts on every tick
//   level_o         out  current speed level
//   state_o         out  0=IDLE 1=RUN 2=PAUSE 3=OVER
//   running_o       out  high iff state is RUN (decoded, not registered)

module game_tick_controller
  import game_pkg::*;
#(
  parameter int BASE_PERIOD      = DEF_BASE_PERIOD,
  parameter int STEP_PERIOD      = DEF_STEP_PERIOD,
  parameter int MIN_PERIOD       = DEF_MIN_PERIOD,
  parameter int CNT_W            = DEF_CNT_W,
  parameter int LEVEL_W          = DEF_LEVEL_W,
  parameter int MAX_LEVEL        = DEF_MAX_LEVEL,
  parameter int APPLES_PER_LEVEL = DEF_APPLES_PER_LEVEL
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start_i,
  input  logic               pause_toggle_i,
  input  logic               collision_i,
  input  logic               apple_eaten_i,
  output logic               tick_o,
  output logic               tick_toggle_o,
  output logic [LEVEL_W-1:0] level_o,
  output logic [1:0]         state_o,
  output logic               running_o
);

  localparam int APPLE_W = (APPLES_PER_LEVEL > 1) ? $clog2(APPLES_PER_LEVEL) : 1;
  localparam logic [APPLE_W-1:0] APPLE_LAST = APPLE_W'(APPLES_PER_LEVEL - 1);
  localparam logic [LEVEL_W-1:0] LEVEL_MAX  = LEVEL_W'(MAX_LEVEL);
  localparam logic [CNT_W-1:0]   BASE_P     = CNT_W'(BASE_PERIOD);

  game_state_e        state_q;
  logic [LEVEL_W-1:0] level_q;
  logic [APPLE_W-1:0] apple_cnt_q;

  logic             in_run;
  logic             start_run;
  logic             leave_run;
  logic             div_enable;
  logic [CNT_W-1:0] next_period;
  logic [CNT_W-1:0] div_period;

  assign in_run    = (state_q == ST_RUN);
  assign start_run = start_i && ((state_q == ST_IDLE) || (state_q == ST_OVER));
  assign leave_run = in_run && (collision_i || pause_toggle_i);

  // The counter is frozen on the edge that leaves RUN, so a tick can never
  // appear in PAUSE/OVER and a paused game resumes exactly where it stopped.
  assign div_enable = in_run && !leave_run;

  // Uses the registered level, so an apple landing on the wrap cycle only
  // changes the period at the following tick boundary.
  assign next_period = CNT_W'(calc_period(32'(level_q), 32'(BASE_PERIOD),
                                          32'(STEP_PERIOD), 32'(MIN_PERIOD)));
  assign div_period  = start_run ? BASE_P : next_period;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      level_q     <= '0;
      apple_cnt_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE, ST_OVER: begin
          if (start_i) begin
            state_q     <= ST_RUN;
            level_q     <= '0;
            apple_cnt_q <= '0;
          end
        end
        ST_RUN: begin
          // A collision drops any apple eaten in the same cycle.
          if (collision_i) begin
            state_q <= ST_OVER;
          end else begin
            if (pause_toggle_i) begin
              state_q <= ST_PAUSE;
            end
            if (apple_eaten_i) begin
              if (apple_cnt_q == APPLE_LAST) begin
                apple_cnt_q <= '0;
                if (level_q < LEVEL_MAX) begin
                  level_q <= level_q + LEVEL_W'(1);
                end
              end else begin
                apple_cnt_q <= apple_cnt_q + APPLE_W'(1);
              end
            end
          end
        end
        ST_PAUSE: begin
          if (collision_i) begin
            state_q <= ST_OVER;
          end else if (pause_toggle_i) begin
            state_q <= ST_RUN;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  tick_divider #(
    .CNT_W        (CNT_W),
    .RESET_PERIOD (BASE_PERIOD)
  ) u_tick_divider (
    .clock         (clock),
    .reset         (reset),
    .enable_i      (div_enable),
    .clear_i       (start_run),
    .period_i      (div_period),
    .tick_o        (tick_o),
    .tick_toggle_o (tick_toggle_o)
  );

  assign level_o   = level_q;
  assign state_o   = state_q;
  assign running_o = in_run;

endmodule

// File: tb/tb_game_tick_controller.sv
// tb/tb_game_tick_controller.sv - scoreboard bench for game_tick_controller with a behavioural reference model

module tb_game_tick_controller;

  localparam int BASE  = 10;
  localparam int STEP  = 2;
  localparam int MINP  = 4;
  localparam int APL   = 2;
  localparam int MAXL  = 4;
  localparam int LVL_W = 3;
  localparam int CW    = 8;

  logic             clock = 1'b0;
  logic             reset;
  logic             start_i, pause_toggle_i, collision_i, apple_eaten_i;
  logic             tick_o, tick_toggle_o, running_o;
  logic [LVL_W-1:0] level_o;
  logic [1:0]       state_o;

  game_tick_controller #(
    .BASE_PERIOD(BASE), .STEP_PERIOD(STEP), .MIN_PERIOD(MINP), .CNT_W(CW),
    .LEVEL_W(LVL_W), .MAX_LEVEL(MAXL), .APPLES_PER_LEVEL(APL)
  ) dut (
    .clock(clock), .reset(reset), .start_i(start_i), .pause_toggle_i(pause_toggle_i),
    .collision_i(collision_i), .apple_eaten_i(apple_eaten_i), .tick_o(tick_o),
    .tick_toggle_o(tick_toggle_o), .level_o(level_o), .state_o(state_o), .running_o(running_o)
  );

  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;
  int edge_cnt = 0;

  // Reference model: game state, speed level, apples toward next level,
  // run cycles elapsed in the current period and that period's length.
  int m_state, m_level, m_apples, m_elapsed, m_period;
  bit m_toggle;

  typedef struct { int edge_no; bit toggle; } tick_exp_t;
  tick_exp_t tq[$];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at edge %0d", name, act, exp, edge_cnt);
    end
  endtask

  function automatic int period_for(input int lvl);
    int p;
    p = BASE - lvl * STEP;
    return (p < MINP) ? MINP : p;
  endfunction

  task automatic model_reset();
    m_state = 0; m_level = 0; m_apples = 0; m_elapsed = 0;
    m_period = BASE; m_toggle = 0;
    tq.delete();
  endtask

  // Predicts the effect of the coming rising edge given this cycle's inputs.
  task automatic model_step(input bit s, input bit p, input bit c, input bit a);
    tick_exp_t e;
    case (m_state)
      0, 3: if (s) begin
        m_state = 1; m_level = 0; m_apples = 0; m_elapsed = 0; m_period = BASE;
      end
      1: begin
        if (c) begin
          m_state = 3;
        end else begin
          if (p) begin
            m_state = 2;
          end else begin
            m_elapsed++;
            if (m_elapsed == m_period) begin
              m_elapsed = 0;
              m_toggle = !m_toggle;
              m_period = period_for(m_level);
              e.edge_no = edge_cnt + 1;
              e.toggle = m_toggle;
              tq.push_back(e);
            end
          end
          if (a) begin
            m_apples++;
            if (m_apples == APL) begin
              m_apples = 0;
              if (m_level < MAXL) m_level++;
            end
          end
        end
      end
      default: begin
        if (c) m_state = 3;
        else if (p) m_state = 1;
      end
    endcase
  endtask

  task automatic cyc(input bit s, input bit p, input bit c, input bit a);
    @(negedge clock);
    start_i = s; pause_toggle_i = p; collision_i = c; apple_eaten_i = a;
    if (!reset) model_step(s, p, c, a);
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(0, 0, 0, 0);
  endtask

  // Monitor: pops expected ticks as the DUT presents them, and compares the
  // registered outputs against the model after every edge.
  initial begin
    bit exp_t;
    forever begin
      @(posedge clock);
      edge_cnt++;
      #2;
      if (!reset) begin
        while (tq.size() > 0 && tq[0].edge_no < edge_cnt) begin
          checks++; errors++;
          $display("FAIL tick_missed: expected tick at edge %0d never seen", tq[0].edge_no);
          void'(tq.pop_front());
        end
        exp_t = (tq.size() > 0) && (tq[0].edge_no == edge_cnt);
        check("tick", int'(tick_o), int'(exp_t));
        if (exp_t) begin
          check("toggle_at_tick", int'(tick_toggle_o), int'(tq[0].toggle));
          void'(tq.pop_front());
        end
        check("state", int'(state_o), m_state);
        check("level", int'(level_o), m_level);
        check("running", int'(running_o), int'(m_state == 1));
        check("tick_toggle", int'(tick_toggle_o), int'(m_toggle));
      end
    end
  end

  initial begin
    reset = 1'b1;
    start_i = 0; pause_toggle_i = 0; collision_i = 0; apple_eaten_i = 0;
    model_reset();
    repeat (3) @(negedge clock);
    check("rst_state", int'(state_o), 0);
    check("rst_level", int'(level_o), 0);
    check("rst_tick", int'(tick_o), 0);
    check("rst_toggle", int'(tick_toggle_o), 0);
    check("rst_running", int'(running_o), 0);
    @(negedge clock);
    reset = 1'b0;
    model_step(0, 0, 0, 0);

    // pause and apple in IDLE are ignored
    cyc(0, 1, 0, 0); cyc(0, 0, 0, 1); idle(3);
    // basic cadence: ticks 10/20/30 cycles after entry
    cyc(1, 0, 0, 0); idle(35);
    // pause mid-period, resume preserves count
    cyc(0, 0, 1, 0); cyc(1, 0, 0, 0); idle(4);
    cyc(0, 1, 0, 0); idle(20); cyc(0, 1, 0, 0); idle(20);
    // level up mid-period, then climb to the floor and saturate
    idle(3); cyc(0, 0, 0, 1); cyc(0, 0, 0, 1); idle(30);
    repeat (4) begin cyc(0, 0, 0, 1); idle(5); end
    idle(20);
    cyc(0, 0, 0, 1); cyc(0, 0, 0, 1); idle(15);
    cyc(0, 0, 0, 1); cyc(0, 0, 0, 1); idle(15);
    // collision + apple + pause together, then restart
    cyc(0, 1, 1, 1); idle(5); cyc(0, 0, 0, 1); cyc(0, 1, 0, 0); idle(2);
    cyc(1, 0, 0, 0); idle(15);
    // reach level 2 then reset between edges
    repeat (4) begin cyc(0, 0, 0, 1); idle(2); end
    idle(3);
    @(posedge clock);
    #3;
    reset = 1'b1;
    model_reset();
    #1;
    check("async_state", int'(state_o), 0);
    check("async_level", int'(level_o), 0);
    check("async_tick", int'(tick_o), 0);
    check("async_toggle", int'(tick_toggle_o), 0);
    check("async_running", int'(running_o), 0);
    repeat (3) begin @(negedge clock); start_i = 1'b1; end
    @(negedge clock);
    check("start_in_reset", int'(state_o), 0);
    start_i = 1'b0;
    reset = 1'b0;
    model_step(0, 0, 0, 0);
    // ignored inputs in RUN, PAUSE and OVER
    cyc(1, 0, 0, 0); idle(3); cyc(1, 0, 0, 0); idle(2);
    cyc(0, 1, 0, 0); cyc(1, 0, 0, 0); cyc(0, 0, 0, 1); cyc(0, 1, 0, 0); idle(12);
    cyc(0, 0, 1, 0); cyc(0, 1, 0, 0); cyc(0, 0, 0, 1); idle(3);
    // randomized play
    repeat (4000) begin
      cyc($urandom_range(0, 39) == 0, $urandom_range(0, 29) == 0,
          $urandom_range(0, 149) == 0, $urandom_range(0, 5) == 0);
    end
    idle(5);
    @(posedge clock);
    #3;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
